hamming_dec_arb: RTL and testbench

HAMMING_DEC_ARB -- requirements
Module: hamming_dec_arb

---
 rtl/hamming_pkg.sv | 18 +
 rtl/rr_arb.sv | 42 ++++
 rtl/hamming_dec_arb.sv | 110 +++++++++++
 tb/tb_hamming_dec_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared Hamming(7,4) constants, codeword type and syndrome helper
package hamming_pkg;

    localparam int N = 7;

    typedef logic [N-1:0] cw_t;

    // Syndrome is the XOR of the 1-based positions of all set bits; zero means a clean codeword.
    function automatic logic [2:0] syndrome(input cw_t cw);
        logic [2:0] s;
        s = 3'd0;
        for (int b = 0; b < N; b++) begin
            if (cw[b]) s = s ^ 3'(b + 1);
        end
        return s;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - round-robin one-hot grant with pointer advancing past the last winner
module rr_arb #(
    parameter int NCH = 4,
    localparam int IW = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  gnt_idx
);

    logic [IW-1:0] ptr;

    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/hamming_dec_arb.sv
// rtl/hamming_dec_arb.sv - multi-channel arbiter in front of a Hamming decoder; HAMMING_ERR_CNT_EN enables error counters
module hamming_dec_arb
    import hamming_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int K       = 4,
    parameter int DEC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   req_val,
    input  logic [NCH*7-1:0] req_cw,
    output logic [NCH-1:0]   req_rdy,
    output logic [6:0]       dec_ein,
    output logic             dec_ein_val,
    input  logic [K-1:0]     dec_dout,
    input  logic             dec_dout_val,
    output logic [NCH-1:0]   rsp_val,
    output logic [K-1:0]     rsp_data,
    output logic             seq_err,
    input  logic             cnt_clr,
    output logic [NCH*8-1:0] err_cnt
);

    localparam int IW = $clog2(NCH);

    logic [IW-1:0] gnt_idx;
    logic          xfer;
    cw_t           xfer_cw;
    logic [IW-1:0] ein_ch;
    logic          pipe_val [DEC_LAT];
    logic [IW-1:0] pipe_ch  [DEC_LAT];

    // Gating with rst keeps req_rdy low throughout reset even though it is combinational.
    rr_arb #(.NCH(NCH)) u_rr_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (en & rst),
        .req     (req_val),
        .gnt     (req_rdy),
        .gnt_idx (gnt_idx)
    );

    assign xfer    = |(req_val & req_rdy);
    assign xfer_cw = req_cw[7*gnt_idx +: 7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_ein     <= '0;
            dec_ein_val <= 1'b0;
            ein_ch      <= '0;
        end else begin
            dec_ein_val <= xfer;
            if (xfer) begin
                dec_ein <= xfer_cw;
                ein_ch  <= gnt_idx;
            end
        end
    end

    // Tag pipe tail lines up with dec_dout_val of the codeword issued DEC_LAT cycles earlier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEC_LAT; i++) begin
                pipe_val[i] <= 1'b0;
                pipe_ch[i]  <= '0;
            end
            rsp_val  <= '0;
            rsp_data <= '0;
            seq_err  <= 1'b0;
        end else begin
            pipe_val[0] <= dec_ein_val;
            pipe_ch[0]  <= ein_ch;
            for (int i = 1; i < DEC_LAT; i++) begin
                pipe_val[i] <= pipe_val[i-1];
                pipe_ch[i]  <= pipe_ch[i-1];
            end
            rsp_val <= '0;
            if (pipe_val[DEC_LAT-1] && dec_dout_val) begin
                rsp_val[pipe_ch[DEC_LAT-1]] <= 1'b1;
                rsp_data                    <= dec_dout;
            end
            if (pipe_val[DEC_LAT-1] != dec_dout_val) seq_err <= 1'b1;
        end
    end

`ifdef HAMMING_ERR_CNT_EN
    logic [7:0] cnt [NCH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else if (xfer && syndrome(xfer_cw) != 3'd0 && cnt[gnt_idx] != 8'hff) begin
            cnt[gnt_idx] <= cnt[gnt_idx] + 8'd1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        assign err_cnt[8*g +: 8] = cnt[g];
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_hamming_dec_arb.sv
// tb/tb_hamming_dec_arb.sv - directed bench for hamming_dec_arb with a one-cycle decoder model
module tb_hamming_dec_arb;

    localparam int NCH = 4;
    localparam int K   = 4;

`ifdef HAMMING_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [NCH-1:0]   req_val = '0;
    logic [NCH*7-1:0] req_cw = '0;
    logic [NCH-1:0]   req_rdy;
    logic [6:0]       dec_ein;
    logic             dec_ein_val;
    logic [K-1:0]     dec_dout;
    logic             dec_dout_val;
    logic [NCH-1:0]   rsp_val;
    logic [K-1:0]     rsp_data;
    logic             seq_err;
    logic             cnt_clr = 1'b0;
    logic [NCH*8-1:0] err_cnt;

    logic [K-1:0] model_dout = '0;
    logic         model_val  = 1'b0;
    logic         force_dv   = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [6:0] cw_tab [NCH];

    always #5 clk = ~clk;

    hamming_dec_arb #(.NCH(NCH), .K(K), .DEC_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .req_val      (req_val),
        .req_cw       (req_cw),
        .req_rdy      (req_rdy),
        .dec_ein      (dec_ein),
        .dec_ein_val  (dec_ein_val),
        .dec_dout     (dec_dout),
        .dec_dout_val (dec_dout_val),
        .rsp_val      (rsp_val),
        .rsp_data     (rsp_data),
        .seq_err      (seq_err),
        .cnt_clr      (cnt_clr),
        .err_cnt      (err_cnt)
    );

    function automatic logic [K-1:0] data_of(input logic [6:0] cw);
        return {cw[6], cw[5], cw[4], cw[2]};
    endfunction

    // Decoder model: data bits of the codeword, one cycle after dec_ein_val.
    always @(posedge clk) begin
        model_val <= dec_ein_val;
        if (dec_ein_val) model_dout <= data_of(dec_ein);
    end
    assign dec_dout     = model_dout;
    assign dec_dout_val = model_val | force_dv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cw_tab[0] = 7'b0000111;
        cw_tab[1] = 7'b0011001;
        cw_tab[2] = 7'b0101010;
        cw_tab[3] = 7'b1111111;

        // Reset state with requests already pending
        en      = 1'b1;
        req_val = 4'b1111;
        for (int i = 0; i < NCH; i++) req_cw[7*i +: 7] = cw_tab[i];
        #3;
        chk("rst_req_rdy", 64'(req_rdy), 64'h0);
        chk("rst_ein_val", 64'(dec_ein_val), 64'h0);
        chk("rst_ein", 64'(dec_ein), 64'h0);
        chk("rst_rsp_val", 64'(rsp_val), 64'h0);
        chk("rst_seq_err", 64'(seq_err), 64'h0);
        chk("rst_err_cnt", 64'(err_cnt), 64'h0);
        tick();
        rst = 1'b1;
        #1;

        // All channels requesting: 0,1,2,3,0,1,2,3 with responses three cycles later
        for (int k = 0; k < 11; k++) begin
            if (k == 8) req_val = 4'b0000;
            #1;
            if (k < 8) chk("rr_grant", 64'(req_rdy), 64'(4'b0001 << (k % 4)));
            else       chk("rr_idle", 64'(req_rdy), 64'h0);
            if (k >= 1 && k <= 8) begin
                chk("rr_ein_val", 64'(dec_ein_val), 64'h1);
                chk("rr_ein", 64'(dec_ein), 64'(cw_tab[(k-1) % 4]));
            end
            if (k >= 3) begin
                chk("rr_rsp_val", 64'(rsp_val), 64'(4'b0001 << ((k-3) % 4)));
                chk("rr_rsp_data", 64'(rsp_data), 64'(data_of(cw_tab[(k-3) % 4])));
            end
            tick();
        end
        chk("rr_rsp_quiet", 64'(rsp_val), 64'h0);
        chk("rr_err_cnt_clean", 64'(err_cnt), 64'h0);
        chk("rr_seq_err", 64'(seq_err), 64'h0);

        // Single channel 2 transfer, latency check
        req_cw[14 +: 7] = 7'b0000001;
        req_val = 4'b0100;
        #1;
        chk("c2_rdy", 64'(req_rdy), 64'h4);
        tick();
        req_val = 4'b0000;
        chk("c2_ein_val", 64'(dec_ein_val), 64'h1);
        chk("c2_ein", 64'(dec_ein), 64'h01);
        tick();
        chk("c2_ein_val_drop", 64'(dec_ein_val), 64'h0);
        chk("c2_ein_hold", 64'(dec_ein), 64'h01);
        chk("c2_rsp_early", 64'(rsp_val), 64'h0);
        tick();
        chk("c2_rsp_val", 64'(rsp_val), 64'h4);
        chk("c2_rsp_data", 64'(rsp_data), 64'(data_of(7'b0000001)));
        chk("c2_err_cnt", 64'(err_cnt[16 +: 8]), CNT_ON ? 64'd1 : 64'd0);
        tick();
        chk("c2_rsp_pulse", 64'(rsp_val), 64'h0);

        // Persistent ch1 requester: back-to-back grants, syndromes 1 then 0
        req_val = 4'b0010;
        req_cw[7 +: 7] = 7'b0000001;
        #1;
        chk("c1_rdy0", 64'(req_rdy), 64'h2);
        tick();
        req_cw[7 +: 7] = 7'b1111111;
        #1;
        chk("c1_rdy1", 64'(req_rdy), 64'h2);
        tick();
        req_val = 4'b0000;
        chk("c1_err_cnt", 64'(err_cnt[8 +: 8]), CNT_ON ? 64'd1 : 64'd0);
        tick();
        chk("c1_rsp0", 64'(rsp_val), 64'h2);
        chk("c1_rsp0_data", 64'(rsp_data), 64'(data_of(7'b0000001)));
        tick();
        chk("c1_rsp1", 64'(rsp_val), 64'h2);
        chk("c1_rsp1_data", 64'(rsp_data), 64'(data_of(7'b1111111)));
        tick();

        // Saturation on ch0
        req_cw[0 +: 7] = 7'b0000001;
        req_val = 4'b0001;
        for (int i = 0; i < 254; i++) tick();
        chk("c0_cnt_254", 64'(err_cnt[0 +: 8]), CNT_ON ? 64'd254 : 64'd0);
        for (int i = 0; i < 46; i++) tick();
        chk("c0_cnt_sat", 64'(err_cnt[0 +: 8]), CNT_ON ? 64'd255 : 64'd0);
        req_val = 4'b0000;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("c0_cnt_clr", 64'(err_cnt), 64'h0);
        req_val = 4'b0001;
        cnt_clr = 1'b1;
        tick();
        req_val = 4'b0000;
        cnt_clr = 1'b0;
        chk("c0_clr_prio", 64'(err_cnt), 64'h0);
        tick();
        tick();
        tick();
        chk("c0_drained", 64'(rsp_val), 64'h0);

        // Drop en with one codeword in flight on ch3
        req_cw[21 +: 7] = 7'b0011001;
        req_val = 4'b1000;
        #1;
        chk("en_rdy", 64'(req_rdy), 64'h8);
        tick();
        en = 1'b0;
        req_val = 4'b1111;
        #1;
        chk("en_off_rdy0", 64'(req_rdy), 64'h0);
        tick();
        chk("en_off_rdy1", 64'(req_rdy), 64'h0);
        tick();
        chk("en_rsp_val", 64'(rsp_val), 64'h8);
        chk("en_rsp_data", 64'(rsp_data), 64'(data_of(7'b0011001)));
        tick();
        chk("en_rsp_pulse", 64'(rsp_val), 64'h0);
        req_val = 4'b0000;

        // Spurious dec_dout_val sets a sticky error
        chk("seq_err_before", 64'(seq_err), 64'h0);
        force_dv = 1'b1;
        tick();
        force_dv = 1'b0;
        chk("seq_err_set", 64'(seq_err), 64'h1);
        chk("seq_err_no_rsp", 64'(rsp_val), 64'h0);
        tick();
        chk("seq_err_sticky", 64'(seq_err), 64'h1);

        // Mid-flight reset drops the tag
        en = 1'b1;
        req_val = 4'b0001;
        req_cw[0 +: 7] = 7'b0101010;
        tick();
        req_val = 4'b0000;
        rst = 1'b0;
        #1;
        chk("mrst_seq_err", 64'(seq_err), 64'h0);
        chk("mrst_ein_val", 64'(dec_ein_val), 64'h0);
        chk("mrst_ein", 64'(dec_ein), 64'h0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_no_rsp", 64'(rsp_val), 64'h0);
        end
        chk("mrst_seq_err_after", 64'(seq_err), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
